// File: rtl/dcache_controller_pkg.sv
// Shared types, geometry constants and address-field helpers for the
// direct-mapped write-back L1 data cache.
package cache_pkg;

  localparam int LINES         = 32;
  localparam int LINE_BITS     = 256;
  localparam int TAG_BITS      = 22;
  localparam int OFFSET_BITS   = 5;
  localparam int INDEX_BITS    = 5;
  localparam int WORD_SEL_BITS = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    FILL      = 2'd3
  } state_t;

  typedef logic [TAG_BITS-1:0]      tag_t;
  typedef logic [INDEX_BITS-1:0]    index_t;
  typedef logic [WORD_SEL_BITS-1:0] word_sel_t;
  typedef logic [LINE_BITS-1:0]     line_t;

  function automatic tag_t get_tag(input logic [31:0] addr);
    return addr[31 -: TAG_BITS];
  endfunction

  function automatic index_t get_index(input logic [31:0] addr);
    return addr[OFFSET_BITS +: INDEX_BITS];
  endfunction

  function automatic word_sel_t get_word(input logic [31:0] addr);
    return addr[OFFSET_BITS-1 -: WORD_SEL_BITS];
  endfunction

  function automatic logic [31:0] line_word(input line_t line, input word_sel_t word);
    return line[{word, 5'b0} +: 32];
  endfunction

endpackage

// File: rtl/dcache_controller_if.sv
// Pipeline-side request/response and memory-side line bus of the data cache.
interface dcache_controller_if;
  import cache_pkg::*;

  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        mem_enable_o;
  logic        mem_write_o;
  logic [31:0] mem_addr_o;
  line_t       mem_data_o;
  line_t       mem_data_i;
  logic        mem_ack_i;

  modport master (
    output MemRead_i, MemWrite_i, addr_i, wdata_i, mem_data_i, mem_ack_i,
    input  rdata_o, stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport slave (
    input  MemRead_i, MemWrite_i, addr_i, wdata_i, mem_data_i, mem_ack_i,
    output rdata_o, stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

endinterface

// File: rtl/dcache_sram.sv
// Tag, valid, dirty and data storage: asynchronous read, synchronous line
// fill and word store, asynchronous clear of valid/dirty.
module dcache_sram
  import cache_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  index_t      idx,
  output tag_t        rd_tag,
  output logic        rd_valid,
  output logic        rd_dirty,
  output line_t       rd_line,
  input  logic        fill_en,
  input  tag_t        fill_tag,
  input  line_t       fill_line,
  input  logic        store_en,
  input  word_sel_t   store_word,
  input  logic [31:0] store_data
);

  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  tag_t             tag_arr  [LINES];
  line_t            data_arr [LINES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (store_en) begin
      dirty[idx] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are deliberately left out of reset; valid bits
  // alone guard them, and a resettable array would prevent RAM inference.
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tag_arr[idx]  <= fill_tag;
      data_arr[idx] <= fill_line;
    end else if (store_en) begin
      data_arr[idx][{store_word, 5'b0} +: 32] <= store_data;
    end
  end

  assign rd_tag   = tag_arr[idx];
  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_line  = data_arr[idx];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate L1 data-cache controller: same-cycle
// hits, miss sequencing (write-back then refill) with a pipeline stall.
module dcache_controller
  import cache_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  dcache_controller_if.slave  bus
);

  state_t      state, next_state;
  tag_t        req_tag;
  index_t      req_idx;
  word_sel_t   req_word;
  logic        req, is_store, hit;

  tag_t        rd_tag;
  logic        rd_valid, rd_dirty;
  line_t       rd_line;
  logic        fill_en, store_en;

  logic        stall, mem_enable, mem_write;
  logic [31:0] mem_addr, rdata;
  line_t       mem_data;

  assign req_tag  = get_tag(bus.addr_i);
  assign req_idx  = get_index(bus.addr_i);
  assign req_word = get_word(bus.addr_i);
  assign req      = bus.MemRead_i | bus.MemWrite_i;
  assign is_store = bus.MemWrite_i;
  assign hit      = rd_valid & (rd_tag == req_tag);

  dcache_sram u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .idx        (req_idx),
    .rd_tag     (rd_tag),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_line    (rd_line),
    .fill_en    (fill_en),
    .fill_tag   (req_tag),
    .fill_line  (bus.mem_data_i),
    .store_en   (store_en),
    .store_word (req_word),
    .store_data (bus.wdata_i)
  );

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours, independent of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    mem_enable = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_data   = '0;
    rdata      = '0;
    fill_en    = 1'b0;
    store_en   = 1'b0;

    // Outputs are held low while reset is asserted so stall and the memory
    // request drop at once, even with a pipeline request still pending.
    if (!rst_i) begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (is_store) store_en = 1'b1;
              else          rdata    = line_word(rd_line, req_word);
            end else begin
              stall      = 1'b1;
              next_state = (rd_valid & rd_dirty) ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          stall      = 1'b1;
          mem_enable = 1'b1;
          mem_write  = 1'b1;
          mem_addr   = {rd_tag, req_idx, {OFFSET_BITS{1'b0}}};
          mem_data   = rd_line;
          if (bus.mem_ack_i) next_state = ALLOCATE;
        end
        ALLOCATE: begin
          stall      = 1'b1;
          mem_enable = 1'b1;
          mem_addr   = {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
          if (bus.mem_ack_i) begin
            fill_en    = 1'b1;
            next_state = FILL;
          end
        end
        FILL: begin
          stall      = 1'b1;
          next_state = IDLE;
        end
      endcase
    end
  end

  assign bus.stall_o      = stall;
  assign bus.mem_enable_o = mem_enable;
  assign bus.mem_write_o  = mem_write;
  assign bus.mem_addr_o   = mem_addr;
  assign bus.mem_data_o   = mem_data;
  assign bus.rdata_o      = rdata;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller with a behavioural
// slow-memory responder driven from the scenario tasks.
module tb_dcache_controller;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   ack_count = 0;

  dcache_controller_if bus();

  dcache_controller dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mem_enable_o && bus.mem_ack_i) ack_count++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic line_t make_line(input logic [31:0] base);
    line_t l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.MemRead_i  = rd;
    bus.MemWrite_i = wr;
    bus.addr_i     = a;
    bus.wdata_i    = d;
    #1;
  endtask

  // Memory responder: waits (bounded) for a request, records it, acks after
  // the given latency in cycles with the given line. Callers do the comparisons.
  task automatic serve(input int latency, input line_t line, output bit seen,
                       output logic first_write, output logic [31:0] first_addr,
                       output line_t first_data, output bit stall_held, output bit write_any);
    seen = 0; stall_held = 0; write_any = 0;
    first_write = 1'bx; first_addr = 'x; first_data = 'x;
    for (int i = 0; i < 50; i++) begin
      if (bus.mem_enable_o) begin seen = 1; break; end
      step();
    end
    if (!seen) return;
    first_write = bus.mem_write_o;
    first_addr  = bus.mem_addr_o;
    first_data  = bus.mem_data_o;
    write_any   = bus.mem_write_o;
    stall_held  = bus.stall_o;
    for (int k = 1; k < latency; k++) begin
      step();
      stall_held &= (bus.stall_o & bus.mem_enable_o);
      write_any  |= bus.mem_write_o;
    end
    step();
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = line;
    step();
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mem_ack_i = 1'b0; bus.mem_data_i = '0;
    drive(0, 0, 32'h0, 32'h0);
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall_o); end
    checks++; if (bus.mem_enable_o !== 1'b0 || bus.mem_write_o !== 1'b0) begin errors++; $display("FAIL reset_mem_ctl: got en=%b wr=%b want 0/0", bus.mem_enable_o, bus.mem_write_o); end
    checks++; if (bus.mem_addr_o !== 32'h0 || bus.mem_data_o !== '0) begin errors++; $display("FAIL reset_mem_bus: got addr=%h want 0", bus.mem_addr_o); end
    checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.rdata_o); end
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_cold_load();
    line_t l1 = make_line(32'hDEADBEEF);
    bit seen, sh, wa; logic fw; logic [31:0] fa; line_t fd;
    step();
    drive(1, 0, 32'h0000_0400, 32'h0);
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL cold_stall_req: got %b want 1", bus.stall_o); end
    checks++; if (bus.mem_enable_o !== 1'b0) begin errors++; $display("FAIL cold_idle_en: got %b want 0", bus.mem_enable_o); end
    step();
    serve(10, l1, seen, fw, fa, fd, sh, wa);
    checks++; if (!seen) begin errors++; $display("FAIL cold_req_seen: got none want mem request"); end
    checks++; if (fa !== 32'h0000_0400) begin errors++; $display("FAIL cold_addr: got %h want 00000400", fa); end
    checks++; if (wa !== 1'b0) begin errors++; $display("FAIL cold_no_write: got %b want 0", wa); end
    checks++; if (sh !== 1'b1) begin errors++; $display("FAIL cold_stall_hold: got %b want 1", sh); end
    checks++; if (bus.stall_o !== 1'b1 || bus.mem_enable_o !== 1'b0) begin errors++; $display("FAIL cold_fill: got stall=%b en=%b want 1/0", bus.stall_o, bus.mem_enable_o); end
    step();
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL cold_done_stall: got %b want 0", bus.stall_o); end
    checks++; if (bus.rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL cold_rdata: got %h want deadbeef", bus.rdata_o); end
  endtask

  task automatic test_hit_load_store();
    step();
    drive(0, 1, 32'h0000_0404, 32'h1234_5678);
    checks++; if (bus.stall_o !== 1'b0 || bus.mem_enable_o !== 1'b0) begin errors++; $display("FAIL hit_store: got stall=%b en=%b want 0/0", bus.stall_o, bus.mem_enable_o); end
    step();
    drive(1, 0, 32'h0000_0404, 32'h0);
    checks++; if (bus.rdata_o !== 32'h1234_5678 || bus.stall_o !== 1'b0) begin errors++; $display("FAIL hit_load_w1: got %h stall=%b want 12345678/0", bus.rdata_o, bus.stall_o); end
    drive(1, 0, 32'h0000_0400, 32'h0);
    checks++; if (bus.rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL hit_load_w0: got %h want deadbeef", bus.rdata_o); end
    drive(1, 0, 32'h0000_041C, 32'h0);
    checks++; if (bus.rdata_o !== 32'hDEADBEF6) begin errors++; $display("FAIL hit_load_w7: got %h want deadbef6", bus.rdata_o); end
  endtask

  task automatic test_dirty_eviction();
    line_t l2 = make_line(32'hA5A5_0800);
    bit seen, sh, wa; logic fw; logic [31:0] fa; line_t fd;
    step();
    drive(1, 0, 32'h0000_0800, 32'h0);
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL evict_stall_req: got %b want 1", bus.stall_o); end
    step();
    serve(3, '0, seen, fw, fa, fd, sh, wa);
    checks++; if (!seen || fw !== 1'b1) begin errors++; $display("FAIL evict_wb_write: got seen=%0d wr=%b want 1/1", seen, fw); end
    checks++; if (fa !== 32'h0000_0400) begin errors++; $display("FAIL evict_wb_addr: got %h want 00000400", fa); end
    checks++; if (fd[63:32] !== 32'h1234_5678 || fd[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL evict_wb_data: got w1=%h w0=%h want 12345678/deadbeef", fd[63:32], fd[31:0]); end
    checks++; if (sh !== 1'b1) begin errors++; $display("FAIL evict_wb_stall: got %b want 1", sh); end
    checks++; if (bus.mem_enable_o !== 1'b1 || bus.mem_write_o !== 1'b0 || bus.mem_addr_o !== 32'h0000_0800) begin errors++; $display("FAIL evict_alloc: got en=%b wr=%b addr=%h want 1/0/00000800", bus.mem_enable_o, bus.mem_write_o, bus.mem_addr_o); end
    checks++; if (bus.mem_data_o !== '0) begin errors++; $display("FAIL evict_alloc_data: got w0=%h want 0", bus.mem_data_o[31:0]); end
    serve(2, l2, seen, fw, fa, fd, sh, wa);
    checks++; if (!seen || wa !== 1'b0) begin errors++; $display("FAIL evict_refill: got seen=%0d wr=%b want 1/0", seen, wa); end
    step();
    checks++; if (bus.rdata_o !== 32'hA5A5_0800 || bus.stall_o !== 1'b0) begin errors++; $display("FAIL evict_rdata: got %h stall=%b want a5a50800/0", bus.rdata_o, bus.stall_o); end
  endtask

  task automatic test_clean_conflict();
    line_t la = make_line(32'h0A00_0000);
    line_t lb = make_line(32'h0B00_0000);
    bit seen, sh, wa; logic fw; logic [31:0] fa; line_t fd;
    step();
    drive(1, 0, 32'h0000_0020, 32'h0);
    step();
    serve(1, la, seen, fw, fa, fd, sh, wa);
    checks++; if (!seen || fw !== 1'b0 || fa !== 32'h0000_0020) begin errors++; $display("FAIL conflict_a_req: got seen=%0d wr=%b addr=%h want 1/0/00000020", seen, fw, fa); end
    step();
    checks++; if (bus.rdata_o !== 32'h0A00_0000) begin errors++; $display("FAIL conflict_a_rdata: got %h want 0a000000", bus.rdata_o); end
    ack_count = 0;
    step();
    drive(1, 0, 32'h0000_0420, 32'h0);
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL conflict_b_stall: got %b want 1", bus.stall_o); end
    step();
    checks++; if (bus.mem_enable_o !== 1'b1 || bus.mem_write_o !== 1'b0 || bus.mem_addr_o !== 32'h0000_0420) begin errors++; $display("FAIL conflict_b_direct: got en=%b wr=%b addr=%h want 1/0/00000420", bus.mem_enable_o, bus.mem_write_o, bus.mem_addr_o); end
    serve(4, lb, seen, fw, fa, fd, sh, wa);
    step();
    checks++; if (bus.rdata_o !== 32'h0B00_0000 || bus.stall_o !== 1'b0) begin errors++; $display("FAIL conflict_b_rdata: got %h stall=%b want 0b000000/0", bus.rdata_o, bus.stall_o); end
    checks++; if (ack_count !== 1) begin errors++; $display("FAIL conflict_req_count: got %0d want 1", ack_count); end
  endtask

  task automatic test_both_store();
    step();
    drive(1, 1, 32'h0000_0424, 32'hCAFE_F00D);
    checks++; if (bus.stall_o !== 1'b0 || bus.mem_enable_o !== 1'b0) begin errors++; $display("FAIL both_hit: got stall=%b en=%b want 0/0", bus.stall_o, bus.mem_enable_o); end
    step();
    drive(1, 0, 32'h0000_0424, 32'h0);
    checks++; if (bus.rdata_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL both_stored: got %h want cafef00d", bus.rdata_o); end
  endtask

  task automatic test_idle_bubbles();
    for (int i = 0; i < 20; i++) begin
      step();
      drive(0, 0, $urandom & 32'hFFFF_FFFC, $urandom);
      checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL bubble_stall[%0d]: got %b want 0", i, bus.stall_o); end
      checks++; if (bus.mem_enable_o !== 1'b0) begin errors++; $display("FAIL bubble_en[%0d]: got %b want 0", i, bus.mem_enable_o); end
      checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL bubble_rdata[%0d]: got %h want 0", i, bus.rdata_o); end
    end
  endtask

  task automatic test_reset_mid_refill();
    line_t l5 = make_line(32'h5555_0000);
    bit seen, sh, wa; logic fw; logic [31:0] fa; line_t fd;
    step();
    drive(1, 0, 32'h0000_1040, 32'h0);
    step();
    checks++; if (bus.mem_enable_o !== 1'b1 || bus.mem_addr_o !== 32'h0000_1040) begin errors++; $display("FAIL rstmid_alloc: got en=%b addr=%h want 1/00001040", bus.mem_enable_o, bus.mem_addr_o); end
    step(); step();
    rst = 1'b1;
    #1;
    checks++; if (bus.stall_o !== 1'b0 || bus.mem_enable_o !== 1'b0) begin errors++; $display("FAIL rstmid_drop: got stall=%b en=%b want 0/0", bus.stall_o, bus.mem_enable_o); end
    drive(0, 0, 32'h0, 32'h0);
    step();
    rst = 1'b0;
    step();
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = make_line(32'hBAD0_0000);
    #1;
    checks++; if (bus.stall_o !== 1'b0 || bus.mem_enable_o !== 1'b0) begin errors++; $display("FAIL rstmid_late_ack: got stall=%b en=%b want 0/0", bus.stall_o, bus.mem_enable_o); end
    step();
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    drive(1, 0, 32'h0000_0800, 32'h0);
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL rstmid_invalid_0800: got stall=%b want 1", bus.stall_o); end
    drive(1, 0, 32'h0000_1040, 32'h0);
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL rstmid_remiss: got stall=%b want 1", bus.stall_o); end
    step();
    serve(2, l5, seen, fw, fa, fd, sh, wa);
    checks++; if (!seen || fw !== 1'b0 || fa !== 32'h0000_1040) begin errors++; $display("FAIL rstmid_refill: got seen=%0d wr=%b addr=%h want 1/0/00001040", seen, fw, fa); end
    step();
    checks++; if (bus.rdata_o !== 32'h5555_0000) begin errors++; $display("FAIL rstmid_rdata: got %h want 55550000", bus.rdata_o); end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_hit_load_store();
    test_dirty_eviction();
    test_clean_conflict();
    test_both_store();
    test_idle_bubbles();
    test_reset_mid_refill();
    drive(0, 0, 32'h0, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
